// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a small FIFO,
// which a bit-timed FSM shifts out LSB first on a single idle-high line.
module uart_tx_dev #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] addr,
  input  logic        re,
  output logic [31:0] rd,
  input  logic        we,
  input  logic [31:0] wd,
  output logic        tx,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q;
  logic [15:0]   div_q;

  state_e        state_q;
  logic [7:0]    shift_q;
  logic [15:0]   bit_len_q, bit_cnt_q;
  logic [2:0]    bit_idx_q;
  logic          tx_q;

  logic empty, full, shifting, push, pop, push_ok, w1c, div_we, bit_end;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign shifting = (state_q != S_IDLE);
  assign pop      = (state_q == S_IDLE) && !empty;
  assign push     = we && (addr[3:2] == 2'd0);
  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign push_ok  = push && (!full || pop);
  assign w1c      = we && (addr[3:2] == 2'd1) && wd[3];
  assign div_we   = we && (addr[3:2] == 2'd2);
  assign bit_end  = (bit_cnt_q == bit_len_q - 16'd1);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      div_q   <= 16'(DIV_RESET);
    end else begin
      count_q <= count_d;
      if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      if (pop)     rptr_q <= rptr_q + PTR_ONE;
      // A dropped byte wins over a clear arriving in the same cycle.
      if (push && !push_ok) ovf_q <= 1'b1;
      else if (w1c)         ovf_q <= 1'b0;
      if (div_we) div_q <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wd[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_len_q <= 16'd1;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            shift_q   <= mem_q[rptr_q];
            bit_len_q <= div_q;
            bit_cnt_q <= '0;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            shift_q   <= shift_q >> 1;
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            bit_cnt_q <= bit_cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            state_q   <= S_IDLE;
          end else begin
            bit_cnt_q <= bit_cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Line level follows the state one cycle later, giving the write-to-start latency.
      tx_q <= (state_q == S_START) ? 1'b0 :
              (state_q == S_DATA)  ? shift_q[0] : 1'b1;
    end
  end

  always_comb begin
    rd = '0;
    case (addr[3:2])
      2'd1:    rd = {16'b0, 8'(count_q), 4'b0, ovf_q, full, empty, shifting};
      2'd2:    rd = {16'b0, div_q};
      default: rd = '0;
    endcase
  end

  assign tx   = tx_q;
  assign busy = shifting | !empty;

  // Strobe and address/data bits that carry no meaning for this device.
  logic unused_ok;
  assign unused_ok = ^{re, addr[31:4], wd[31:16]};

endmodule

// File: tb/tb_uart_tx_dev.sv
// Bench for uart_tx_dev: register/FIFO checks plus a UART line decoder that
// compares every captured frame against queued bytes and their bit lengths.
module tb_uart_tx_dev;

  logic        clk = 1'b0;
  logic        rst, re, we, tx, busy;
  logic [31:2] addr;
  logic [31:0] rd, wd;

  uart_tx_dev #(.FIFO_DEPTH(8), .DIV_RESET(868)) dut (
    .clk(clk), .rst(rst), .addr(addr), .re(re), .rd(rd),
    .we(we), .wd(wd), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit         cap = 1'b0;
  logic       txq[$];
  logic [7:0] eb_q[$];
  int         ed_q[$];

  always @(posedge clk) begin
    #1;
    if (cap) txq.push_back(tx);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = {28'($urandom), a};
    wd   = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic rdreg(input logic [1:0] a, output logic [31:0] d);
    addr = {28'($urandom), a};
    re   = 1'($urandom);
    #1 d = rd;
  endtask

  task automatic start_cap();
    txq.delete();
    eb_q.delete();
    ed_q.delete();
    cap = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // Receiver view of the line: idle 1s, then 10*div samples per frame.
  task automatic analyze(input int lead);
    int i = 0, found = 0, idle, d, glitch, extra = 0;
    logic [9:0] obs, expv;
    cap = 1'b0;
    while (found < eb_q.size()) begin
      idle = 0;
      while (i < txq.size() && txq[i] == 1'b1) begin
        idle++;
        i++;
      end
      d = ed_q[found];
      if (i + 10*d > txq.size()) break;
      if (found == 0) chk("lead", idle, lead);
      else            chk("gap", idle, 1);
      obs = '0;
      glitch = 0;
      for (int j = 0; j < 10*d; j++) begin
        if (j % d == 0)                    obs[j/d] = txq[i+j];
        else if (txq[i+j] !== obs[j/d])    glitch++;
      end
      expv = {1'b1, eb_q[found], 1'b0};
      chk("frame", obs, expv);
      chk("bit_len", glitch, 0);
      i += 10*d;
      found++;
    end
    while (i < txq.size()) begin
      if (txq[i] !== 1'b1) extra++;
      i++;
    end
    chk("nframes", found, eb_q.size());
    chk("tail_idle", extra, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    int          d, n;

    rst = 1'b1; we = 1'b0; re = 1'b0; wd = '0; addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rdreg(2'd0, v); chk("rst_data", v, 32'd0);
    rdreg(2'd1, v); chk("rst_status", v, 32'h2);
    rdreg(2'd2, v); chk("rst_div", v, 32'd868);
    rdreg(2'd3, v); chk("rst_rsvd", v, 32'd0);

    wr(2'd2, 32'h0);           rdreg(2'd2, v); chk("div_zero", v, 32'd1);
    wr(2'd2, 32'hABCD_0007);   rdreg(2'd2, v); chk("div_upper", v, 32'd7);
    wr(2'd3, 32'hFFFF_FFFF);   rdreg(2'd3, v); chk("rsvd_wr", v, 32'd0);
    rdreg(2'd1, v); chk("rsvd_status", v, 32'h2);
    wr(2'd1, 32'hFFFF_FFFF);   rdreg(2'd1, v); chk("status_wr", v, 32'h2);

    // Single word store, 4 cycles per bit
    wr(2'd2, 32'd4);
    start_cap();
    wr(2'd0, 32'h0000_00A5);
    eb_q.push_back(8'hA5); ed_q.push_back(4);
    chk("busy_on", {31'b0, busy}, 32'd1);
    rdreg(2'd1, v); chk("push_vis", v, 32'h100);
    wait_idle();
    analyze(2);

    // Byte store already merged into the word
    wr(2'd2, 32'd2);
    start_cap();
    wr(2'd0, 32'h0000_003C);
    eb_q.push_back(8'h3C); ed_q.push_back(2);
    wait_idle();
    analyze(2);

    // Divisor change mid-frame applies to the following frame only
    wr(2'd2, 32'd3);
    start_cap();
    wr(2'd0, 32'h0000_005A);
    wr(2'd0, 32'h0000_00C3);
    wr(2'd2, 32'd5);
    eb_q.push_back(8'h5A); ed_q.push_back(3);
    eb_q.push_back(8'hC3); ed_q.push_back(5);
    wait_idle();
    analyze(2);

    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(2, 5);
      n = $urandom_range(1, 8);
      wr(2'd2, 32'(d));
      start_cap();
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        wr(2'd0, {24'($urandom), b});
        eb_q.push_back(b);
        ed_q.push_back(d);
      end
      @(negedge clk);
      rdreg(2'd1, v);
      chk("burst_status", v, {16'b0, 8'(n-1), 4'b0, 2'b00, (n == 1), 1'b1});
      wait_idle();
      analyze(2);
    end

    // Overflow: one byte in flight, eight queued, tenth dropped
    wr(2'd2, 32'd100);
    for (int k = 0; k < 9; k++) wr(2'd0, 32'(k));
    rdreg(2'd1, v); chk("fill", v, 32'h0000_0805);
    wr(2'd0, 32'h9);
    rdreg(2'd1, v); chk("ovf", v, 32'h0000_080D);
    wr(2'd1, 32'h7);
    rdreg(2'd1, v); chk("w1c_nobit", v, 32'h0000_080D);
    wr(2'd1, 32'h8);
    rdreg(2'd1, v); chk("w1c", v, 32'h0000_0805);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rdreg(2'd1, v); chk("ovf_rst", v, 32'h2);

    // Reset while shifting data bits with bytes still queued
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h00);
    wr(2'd0, 32'h22);
    wr(2'd0, 32'h33);
    wr(2'd0, 32'h44);
    repeat (6) @(negedge clk);
    chk("mid_tx_low", {31'b0, tx}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_tx", {31'b0, tx}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    rdreg(2'd1, v); chk("abort_status", v, 32'h2);
    @(negedge clk);
    rst = 1'b0;
    start_cap();
    repeat (200) @(negedge clk);
    analyze(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_dev.md
# uart_tx_dev

Memory-mapped UART transmitter that sits directly downstream of the core's memory management unit as one of its devices. It consumes the per-device word address, read/write strobes and merged write word, and returns a combinational read word. Bytes written by the CPU are queued in a small FIFO and shifted out 8N1, LSB first, on a single serial line. Mapped as a read/write device occupying 16 bytes (four word registers).

## Interface

- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥ 2
- DIV_RESET, 868, reset value of the baud divisor (clock cycles per serial bit)

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- addr  in  [31:2]  device-local word address; only addr[3:2] decoded, upper bits ignored
- re  in  1  read strobe
- rd  out  32  read word; combinational from addr and current state
- we  in  1  write strobe
- wd  in  32  full merged write word (sub-word stores already merged by the MMU)
- tx  out  1  serial output, idle high
- busy  out  1  high while a frame is being shifted or the FIFO is non-empty

## Operation

Byte order within a word is big-endian: offset 3 maps to wd[7:0], so `sb` to base+3 or `sw` to base both set the data byte.

Register map, selected by addr[3:2]:
- 0 DATA: write pushes wd[7:0] into the FIFO; read returns 0
- 1 STATUS: read {16'b0, count[7:0], 4'b0, overflow, full, empty, shifting}; write with wd[3]=1 clears overflow (W1C), other bits ignored
- 2 DIV: read {16'b0, div[15:0]}; write sets div = wd[15:0], a written 0 is stored as 1
- 3 reserved: reads 0, writes ignored

rd depends only on addr and state, never on re: the MMU reads the current word to merge sub-word stores in the same cycle. re has no side effects.

FIFO:
- Push on `we && addr[3:2]==0`. Accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
- A rejected push drops the byte and sets overflow (sticky until W1C or reset).
- count is 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.

Transmit FSM:
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1. If FIFO is non-empty, pop the head into an 8-bit shift register, latch div into bit_len, go to START.
- START: tx=0 for bit_len cycles, then go to DATA with bit index 0.
- DATA: tx = shift[0] for bit_len cycles, then shift right. After the 8th bit, go to STOP.
- STOP: tx=1 for bit_len cycles, then go to IDLE.
- A bit counter counts 0..bit_len−1. DIV writes mid-frame take effect at the next frame.
- shifting = (state != IDLE). busy = shifting | !empty.

## Timing

- Reset values: tx=1, state IDLE, count 0, empty=1, full=0, overflow=0, div=DIV_RESET, busy=0, pointers 0.
- Reset mid-frame aborts the frame immediately; tx returns to 1 the next cycle and the FIFO contents are discarded.
- The push is visible in STATUS the cycle after the write edge.
- From a write to an empty FIFO with the FSM IDLE at edge t:
  - pop at t+1
  - tx falls at t+2
- Frame length: exactly 10·bit_len cycles of START+DATA+STOP. Back-to-back frames add one IDLE cycle between the stop bit and the next start bit.
- Simultaneous push and W1C of overflow: the clear takes priority only if the push is accepted. A rejected push in the same cycle leaves overflow=1.
- Simultaneous push and pop when full: push accepted, count unchanged, overflow unchanged.

## Test plan

- Reset, read all four registers → DATA=0, STATUS=0x00000002, DIV=868, reserved=0; tx=1.
- DIV=4, `sw` 0x000000A5 to DATA → tx low for 4 cycles starting 2 cycles after the write. Then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4 cycles. busy drops after the stop bit.
- DIV=2, `sb` 0x3C at byte offset 3 of DATA → identical to `sw` 0x3C. Frame carries 0x3C; no byte is lost or duplicated.
- FIFO_DEPTH=8, DIV=100, 10 back-to-back DATA writes:
  - first byte is popped immediately; the next 8 fill the FIFO
  - count=8, full=1, 10th write dropped, overflow=1
  - write STATUS 0x8 → overflow=0
- DIV=3 mid-frame, write DIV=5 → current frame keeps 3 cycles/bit, next frame uses 5. Writing DIV=0 reads back as 1.
- Assert rst during the DATA state with 3 bytes queued → next cycle tx=1, STATUS=0x00000002, no further frames.
